// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Serialises a WIDTH-bit word LSB first.
//   The word is sent either unchanged or as its two's complement.
//   The two's complement is formed serially: bits up to and including the
//   first 1 pass through unchanged, and every later bit is inverted.
//
// Optional feature (macro SER_TX_PARITY_EN):
//   Appends one even-parity bit after the data bits.
//   The parity bit is the XOR of the transmitted bits, after negation.
//
// Parameter:
//   WIDTH       data bits per word (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   data_in     word to send; bit 0 goes first
//   neg         1 = send the two's complement of data_in
//   load_valid  data_in/neg offered this cycle
//   load_ready  block accepts a word this cycle
//   out_bit     serial data, registered
//   out_valid   out_bit carries a frame bit, registered
//   first_bit   first bit of a frame, registered
//   last_bit    final bit of a frame, registered
module serial_word_tx #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             neg,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             first_bit,
  output logic             last_bit
);

`ifdef SER_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, COPY, INVERT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, COPY, INVERT} state_t;
`endif

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT    = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_CNT_M1 = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh;        // bits not yet sent, next one in sh[0]
  logic [CW-1:0]    cnt;       // data bits already placed on out_bit
  logic             neg_f;     // mode flag captured with the word
  logic             par;       // running XOR of transmitted data bits
  logic             accept;
  logic             data_bit;

  // Transmit a word as-is in COPY, or with inverted bits in INVERT
  function automatic logic tx_bit(input logic raw, input logic inv);
    return raw ^ inv;
  endfunction

  // last_bit is high exactly in the final frame bit cycle, so it also marks
  // the back-to-back load window
  assign load_ready = !reset && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign data_bit   = tx_bit(sh[0], state == INVERT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      neg_f     <= 1'b0;
      par       <= 1'b0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      first_bit <= 1'b0;
      last_bit  <= 1'b0;
    end else if (accept) begin
      // Bit 0 is always sent unchanged.
      // If it is already the first 1 of a negated word, invert from bit 1.
      out_bit   <= data_in[0];
      out_valid <= 1'b1;
      first_bit <= 1'b1;
      last_bit  <= 1'b0;
      sh        <= data_in >> 1;
      neg_f     <= neg;
      par       <= data_in[0];
      cnt       <= CW'(1);
      state     <= (neg && data_in[0]) ? INVERT : COPY;
    end else begin
      first_bit <= 1'b0;
      case (state)
        COPY, INVERT: begin
          if (cnt != LAST_CNT) begin
            out_bit   <= data_bit;
            out_valid <= 1'b1;
            par       <= par ^ data_bit;
            sh        <= sh >> 1;
            cnt       <= cnt + CW'(1);
`ifdef SER_TX_PARITY_EN
            last_bit  <= 1'b0;
`else
            last_bit  <= (cnt == LAST_CNT_M1);
`endif
            // The first 1 of a negated word passes unchanged.
            // Every bit after it is inverted.
            if ((state == COPY) && neg_f && sh[0])
              state <= INVERT;
          end else begin
`ifdef SER_TX_PARITY_EN
            out_bit   <= par;
            out_valid <= 1'b1;
            last_bit  <= 1'b1;
            state     <= PARITY;
`else
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            last_bit  <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
`ifdef SER_TX_PARITY_EN
        PARITY: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          last_bit  <= 1'b0;
          state     <= IDLE;
        end
`endif
        default: begin
          out_bit   <= 1'b0;
          out_valid <= 1'b0;
          last_bit  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx
//   Directed bench for serial_word_tx with WIDTH=6.
//   Expected bit patterns are hand-computed two's complements, given LSB first.
//   Honours SER_TX_PARITY_EN when defined.
module tb_serial_word_tx;

  localparam int W = 6;
`ifdef SER_TX_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         neg;
  logic         load_valid;
  logic         load_ready;
  logic         out_bit;
  logic         out_valid;
  logic         first_bit;
  logic         last_bit;

  int checks   = 0;
  int failures = 0;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .neg        (neg),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .first_bit  (first_bit),
    .last_bit   (last_bit)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_bit"},   32'(out_bit),   32'd0);
    chk({tag, "_idle_first"}, 32'(first_bit), 32'd0);
    chk({tag, "_idle_last"},  32'(last_bit),  32'd0);
    chk({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Check a frame whose bit 0 is on the outputs now.
  // Afterwards the outputs are one cycle past the final bit.
  task automatic frame(input string tag, input logic [W-1:0] exp, input logic expp);
    logic eb;
    for (int i = 0; i < FLEN; i++) begin
      eb = (i < W) ? exp[i] : expp;
      chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_bit%0d", tag, i), 32'(out_bit), 32'(eb));
      chk($sformatf("%s_first%0d", tag, i), 32'(first_bit), 32'(i == 0));
      chk($sformatf("%s_last%0d", tag, i), 32'(last_bit), 32'(i == FLEN - 1));
      chk($sformatf("%s_ready%0d", tag, i), 32'(load_ready), 32'(i == FLEN - 1));
      step();
    end
  endtask

  // Offer a word for one cycle, then scramble the inputs.
  // The frame in flight must not change.
  task automatic send(input string tag, input logic [W-1:0] d, input logic n,
                      input logic [W-1:0] exp, input logic expp);
    data_in    = d;
    neg        = n;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    data_in    = ~d;
    neg        = ~n;
    frame(tag, exp, expp);
    chk_idle(tag);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    neg        = 1'b0;
    load_valid = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bit",   32'(out_bit),   32'd0);
    chk("rst_first", 32'(first_bit), 32'd0);
    chk("rst_last",  32'(last_bit),  32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    reset      = 1'b0;
    #1;
    chk("post_rst_ready", 32'(load_ready), 32'd1);
    step();
    chk_idle("post_rst");

    // 100111 negated is 011001.
    send("neg_100111", 6'b100111, 1'b1, 6'b011001, 1'b1);
    // Sent unchanged.
    send("pos_100111", 6'b100111, 1'b0, 6'b100111, 1'b0);
    // Negating zero gives zero.
    send("neg_zero",   6'b000000, 1'b1, 6'b000000, 1'b0);
    // Negating the most negative value gives the same value (mod 2^6).
    send("neg_min",    6'b100000, 1'b1, 6'b100000, 1'b1);
    // The first 1 is at bit 1.
    send("neg_000110", 6'b000110, 1'b1, 6'b111010, 1'b0);

    // Back-to-back: load_valid is held, and the second word waits for the final bit
    data_in    = 6'b000001;
    neg        = 1'b1;
    load_valid = 1'b1;
    step();
    data_in = 6'b101010;
    neg     = 1'b0;
    frame("b2b_a", 6'b111111, 1'b0);
    load_valid = 1'b0;
    data_in    = 6'b010101;
    neg        = 1'b1;
    frame("b2b_b", 6'b101010, 1'b1);
    chk_idle("b2b");

    // Reset during bit 3 aborts the frame.
    // A word offered on the reset edge is ignored.
    data_in    = 6'b100111;
    neg        = 1'b0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_bit3_valid", 32'(out_valid), 32'd1);
    chk("mid_bit3_bit",   32'(out_bit),   32'd0);
    reset      = 1'b1;
    load_valid = 1'b1;
    data_in    = 6'b111111;
    #1;
    chk("mid_rst_ready", 32'(load_ready), 32'd0);
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last",  32'(last_bit),  32'd0);
    reset      = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("mid_post_ready", 32'(load_ready), 32'd1);
    step();
    chk_idle("mid_post");
    send("after_rst", 6'b000110, 1'b1, 6'b111010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter: WIDTH, default 6, number of data bits per word (WIDTH >= 2).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 data_in  input  WIDTH  parallel word to transmit; bit 0 is sent first.
REQ-005 neg  input  1  sampled with data_in; 1 means transmit the two's complement of data_in, 0 means transmit data_in unchanged.
REQ-006 load_valid  input  1  data_in/neg valid this cycle.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 out_bit  output  1  serial data, LSB first, registered.
REQ-009 out_valid  output  1  out_bit carries a frame bit this cycle, registered.
REQ-010 first_bit  output  1  high with the first bit of a frame, registered.
REQ-011 last_bit  output  1  high with the final bit of a frame (data or parity), registered.

Function
REQ-012 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; data_in and neg are captured into an internal shift register and mode flag.
REQ-013 Latency: bit i of the frame SHALL appear on out_bit in cycle i+1 after the accepting edge, with out_valid=1; one bit per clock, no gaps within a frame.
REQ-014 FSM states: IDLE, COPY, INVERT (plus PARITY when configured); IDLE -> COPY on accept; COPY -> INVERT after emitting the first 1 bit when neg=1; COPY/INVERT -> IDLE after the last data bit unless a new word is accepted that cycle.
REQ-015 neg=0: all bits SHALL be emitted unchanged, FSM stays in COPY.
REQ-016 neg=1: bits up to and including the first 1 (from LSB) SHALL be emitted unchanged; every later bit SHALL be inverted (INVERT state).
REQ-017 Result is modulo 2^WIDTH: neg of zero emits all zeros; neg of 100..0 emits 100..0.
REQ-018 load_ready SHALL be 1 in IDLE and during the final frame bit cycle, 0 otherwise and 0 whenever reset is high.
REQ-019 Accepting a word during the final bit cycle SHALL start the new frame in the next cycle with no idle cycle (back-to-back); the mode flag resets to COPY for the new word.
REQ-020 In IDLE, out_bit, out_valid, first_bit and last_bit SHALL be 0.
REQ-021 load_valid without load_ready SHALL be ignored; data_in/neg changes mid-frame SHALL not affect the frame in flight.

Reset
REQ-022 On a rising edge with reset=1, the FSM SHALL enter IDLE and out_bit, out_valid, first_bit, last_bit SHALL be 0 from the next cycle; shift register and bit counter cleared.
REQ-023 Reset mid-frame SHALL abort the frame; no remaining bits are emitted, and no word is accepted on that edge.
REQ-024 After reset deasserts, load_ready SHALL be 1 in the first cycle.

Configuration
REQ-025 Macro SER_TX_PARITY_EN: when defined, one even-parity bit (XOR of all WIDTH transmitted bits, after negation) SHALL follow the last data bit in state PARITY; last_bit and the load_ready window move to the parity cycle; frame length WIDTH+1.
REQ-026 Without SER_TX_PARITY_EN: no PARITY state, frame length WIDTH, last_bit on data bit WIDTH-1.

Verification
REQ-027 WIDTH=6, data_in=6'b100111, neg=1 -> out_bit sequence LSB first 1,0,0,1,1,0 (=6'b011001), first_bit on bit 0, last_bit on bit 5.
REQ-028 data_in=6'b100111, neg=0 -> 1,1,1,0,0,1; then neg=1, data_in=0 -> six 0s.
REQ-029 Two words back-to-back (6'b000001 neg=1, then 6'b101010 neg=0, load_valid held) -> 12 consecutive out_valid cycles: 1,1,1,1,1,1 then 0,1,0,1,0,1.
REQ-030 reset asserted during bit 3 of a frame -> out_valid=0 next cycle, load_ready=1 the cycle after reset deasserts, next word transmitted correctly.
REQ-031 With SER_TX_PARITY_EN, 6'b100111 neg=1 -> 1,0,0,1,1,0 then parity 1; last_bit only on parity cycle; without macro, last_bit on bit 5.
